// File: rtl/adder_pipe_harness.sv
// adder_pipe_harness: valid/ready register harness (S1 operands -> prefix adder -> S2 sum)
// around a generated Kogge-Stone prefix-tree adder, with a count of accepted beats.
// Optional build macro ADDER_PIPE_FLAGS_EN adds the registered out_zero and out_ovf flags.
// With the macro undefined, neither flag port nor any flag logic exists.

module adder_pipe_ks #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    // Position 0 of the prefix vectors carries cin as a pure generate, so every
    // group (g,p) that reaches down to position 0 is the true carry out of that bit.
    localparam int N  = WIDTH + 1;
    localparam int LV = $clog2(N);

    logic [N-1:0] g0;
    logic [N-1:0] p0;

    assign g0 = {a & b, cin};
    assign p0 = {a ^ b, 1'b0};

    for (genvar l = 0; l < LV; l++) begin : g_lvl
        localparam int D = 1 << l;
        logic [N-1:0] g;
        logic [N-1:0] p;
        if (l == 0) begin : g_first
            assign g = g0 | (p0 & (g0 << D));
            assign p = p0 & (p0 << D);
        end else begin : g_next
            assign g = g_lvl[l-1].g | (g_lvl[l-1].p & (g_lvl[l-1].g << D));
            assign p = g_lvl[l-1].p & (g_lvl[l-1].p << D);
        end
    end

    assign sum  = (a ^ b) ^ g_lvl[LV-1].g[N-2:0];
    assign cout = g_lvl[LV-1].g[N-1];
endmodule

module adder_pipe_harness #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_cin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_sum,
    output logic                 out_cout,
    output logic [CNT_WIDTH-1:0] txn_count
`ifdef ADDER_PIPE_FLAGS_EN
    ,
    output logic                 out_zero,
    output logic                 out_ovf
`endif
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [WIDTH-1:0] core_sum;
    logic             core_cout;
    logic             adv;
    logic             in_fire;
    logic             out_fire;

    // S1 moves into S2 whenever S2 is empty or being drained this cycle.
    assign adv      = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | adv;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // The core only ever sees registered operands, giving a clean reg-to-reg path.
    adder_pipe_ks #(.WIDTH(WIDTH)) u_core (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .sum  (core_sum),
        .cout (core_cout)
    );

    // S1 operand stage: operands load only on an accepted beat, so idle X never enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_cin   <= in_cin;
        end else if (adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 result stage: holds steady while stalled, refills in the same cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
        end else if (adv) begin
            out_valid <= 1'b1;
            out_sum   <= core_sum;
            out_cout  <= core_cout;
        end else if (out_fire) begin
            out_valid <= 1'b0;
        end
    end

    // Accepted-beat counter, wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (in_fire) begin
            txn_count <= txn_count + 1'b1;
        end
    end

`ifdef ADDER_PIPE_FLAGS_EN
    // Result flags travel with the sum into S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_zero <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (adv) begin
            out_zero <= (core_sum == '0);
            out_ovf  <= (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (core_sum[WIDTH-1] != s1_a[WIDTH-1]);
        end
    end
`endif
endmodule

// File: tb/tb_adder_pipe_harness.sv
// Randomized bench for adder_pipe_harness against a queue-based scoreboard model.
// Built with CNT_WIDTH=4 so counter wrap is reachable; flag checks follow ADDER_PIPE_FLAGS_EN.

module tb_adder_pipe_harness;
    localparam int W  = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic [CW-1:0] txn_count;
`ifdef ADDER_PIPE_FLAGS_EN
    logic          out_zero;
    logic          out_ovf;
`endif

    always #5 clk = ~clk;

    adder_pipe_harness #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .txn_count (txn_count)
`ifdef ADDER_PIPE_FLAGS_EN
        ,
        .out_zero  (out_zero),
        .out_ovf   (out_ovf)
`endif
    );

    typedef struct {
        logic [W:0]   res;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           cyc;
    } beat_t;

    beat_t        q[$];
    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    int           accepted = 0;
    int           delivered = 0;
    logic [W-1:0] cur_a;
    logic [W-1:0] cur_b;
    logic         cur_c;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic new_beat();
        cur_a = $urandom;
        cur_b = $urandom;
        cur_c = 1'($urandom_range(0, 1));
    endtask

    // One clock: drive after the edge, check and advance the model at the falling edge.
    task automatic cycle(input logic v, input logic ordy);
        beat_t      nb;
        logic       exp_ir;
        logic       exp_ov;
        logic [W:0] r;
        @(posedge clk);
        #1;
        in_valid  = v;
        out_ready = ordy;
        if (v) begin
            in_a = cur_a; in_b = cur_b; in_cin = cur_c;
        end else begin
            in_a = 'x; in_b = 'x; in_cin = 1'bx;
        end
        @(negedge clk);
        exp_ir = (q.size() < 2) || ordy;
        exp_ov = 1'b0;
        if (q.size() > 0) exp_ov = (cyc >= q[0].cyc + 2);
        chk("in_ready", 64'(in_ready), 64'(exp_ir));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        chk("txn_count", 64'(txn_count), 64'(accepted % (1 << CW)));
        if (exp_ov) begin
            r = q[0].res;
            chk("out_sum", 64'(out_sum), 64'(r[W-1:0]));
            chk("out_cout", 64'(out_cout), 64'(r[W]));
`ifdef ADDER_PIPE_FLAGS_EN
            chk("out_zero", 64'(out_zero), 64'(r[W-1:0] == '0));
            chk("out_ovf", 64'(out_ovf),
                64'((q[0].a[W-1] == q[0].b[W-1]) && (r[W-1] != q[0].a[W-1])));
`endif
            if (ordy) begin
                void'(q.pop_front());
                delivered++;
            end
        end
        if (v && exp_ir) begin
            nb.a   = cur_a;
            nb.b   = cur_b;
            nb.res = {1'b0, cur_a} + {1'b0, cur_b} + {{W{1'b0}}, cur_c};
            nb.cyc = cyc;
            q.push_back(nb);
            accepted++;
            new_beat();
        end
        cyc++;
    endtask

    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        in_valid = 1'b0;
        q.delete();
        accepted = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int a0;
        int d0;
        in_valid = 1'b1; out_ready = 1'b1;
        in_a = $urandom; in_b = $urandom; in_cin = 1'b1;
        new_beat();

        // Reset with live inputs
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_sum", 64'(out_sum), 64'd0);
        chk("rst_out_cout", 64'(out_cout), 64'd0);
        chk("rst_txn", 64'(txn_count), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat carry-through
        cur_a = 32'hFFFF_FFFF; cur_b = 32'h1; cur_c = 1'b0;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        chk("single_early", 64'(out_valid), 64'd0);
        cycle(1'b0, 1'b1);
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_sum", 64'(out_sum), 64'd0);
        chk("single_cout", 64'(out_cout), 64'd1);
        cycle(1'b0, 1'b1);

        // Back-to-back streaming
        a0 = accepted; d0 = delivered;
        repeat (100) cycle(1'b1, 1'b1);
        repeat (4) cycle(1'b0, 1'b1);
        chk("stream_accepted", 64'(accepted - a0), 64'd100);
        chk("stream_delivered", 64'(delivered - d0), 64'd100);
        chk("stream_empty", 64'(q.size()), 64'd0);

        // Backpressure
        a0 = accepted; d0 = delivered;
        repeat (5) cycle(1'b1, 1'b0);
        chk("bp_accepts", 64'(accepted - a0), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        repeat (3) cycle(1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b1);
        chk("bp_no_loss", 64'(delivered - d0), 64'(accepted - a0));
        chk("bp_empty", 64'(q.size()), 64'd0);

        // Counter wrap and signed overflow edge
        do_reset();
        repeat (17) cycle(1'b1, 1'b1);
        repeat (3) cycle(1'b0, 1'b1);
        chk("wrap_txn", 64'(txn_count), 64'd1);
        cur_a = 32'h7FFF_FFFF; cur_b = 32'h1; cur_c = 1'b0;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        chk("ovf_sum", 64'(out_sum), 64'h8000_0000);
        chk("ovf_cout", 64'(out_cout), 64'd0);
        cycle(1'b0, 1'b1);

        // Reset with two beats in flight
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(out_sum), 64'd0);
        chk("mid_rst_txn", 64'(txn_count), 64'd0);
        in_valid = 1'b0;
        q.delete();
        accepted = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cur_a = 32'h1234_5678; cur_b = 32'h1111_1111; cur_c = 1'b1;
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_sum", 64'(out_sum), 64'h2345_678A);

        // Random traffic with random backpressure
        repeat (400) cycle(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        repeat (6) cycle(1'b0, 1'b1);
        chk("final_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
